// File: rtl/code_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : code_mem_ctrl_pkg
// Description : Shared types and constants for the code memory controller:
//               FSM state encoding, width defaults and the default image
//               (protected BIOS words followed by the user program image).
// Revision    : 1.0 - initial release
// ============================================================================
package code_mem_ctrl_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 6;
  localparam int IMAGE_WORDS    = 2 ** ADDR_W_DEF;
  localparam int BIOS_WORDS_DEF = 32;

  // Two-state controller: copying the default image, or serving the CPU.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  typedef logic [IMAGE_WORDS-1:0][DATA_W_DEF-1:0] image_t;

  // BIOS words carry a 0xB tag with their address in the low bits; the user
  // program region is filled with an address-derived pattern.
  function automatic image_t build_image();
    image_t img;
    for (int i = 0; i < IMAGE_WORDS; i++) begin
      if (i < BIOS_WORDS_DEF) begin
        img[i[ADDR_W_DEF-1:0]] = DATA_W_DEF'(32'hB000 + 32'(i));
      end else begin
        img[i[ADDR_W_DEF-1:0]] = DATA_W_DEF'(32'h4000 + 32'(i) * 32'd37);
      end
    end
    return img;
  endfunction

  localparam image_t DEFAULT_IMAGE = build_image();

endpackage : code_mem_ctrl_pkg
`default_nettype wire

// File: rtl/code_default_rom.sv
`default_nettype none
// ============================================================================
// Module      : code_default_rom
// Description : Combinational lookup of the default code image by address.
//               Addresses outside the stored image read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module code_default_rom
  import code_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Select the image word whose index matches the requested address.
  always_comb begin
    data = '0;
    for (int i = 0; i < IMAGE_WORDS; i++) begin
      if ((i < 2 ** ADDR_W) && (addr == ADDR_W'(i))) begin
        data = DATA_W'(DEFAULT_IMAGE[i[ADDR_W_DEF-1:0]]);
      end
    end
  end

endmodule : code_default_rom
`default_nettype wire

// File: rtl/code_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : code_mem_ctrl
// Description : Code memory controller. After reset (or on reload) it copies
//               the default image into a 1W/1R RAM, one word per cycle, then
//               serves registered CPU reads and guarded loader writes. The
//               BIOS region is write-protected and all writes are refused
//               while the CPU runs.
// Revision    : 1.0 - initial release
// ============================================================================
module code_mem_ctrl
  import code_mem_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BIOS_WORDS = BIOS_WORDS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              reload,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_err
);

  localparam int                c_depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(c_depth - 1);
  // One extra bit so BIOS_WORDS == DEPTH (everything protected) is representable.
  localparam logic [ADDR_W:0]   c_bios_lim = (ADDR_W + 1)'(BIOS_WORDS);

  logic [DATA_W-1:0] r_mem [c_depth];

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_wr_err;

  logic              w_ready;
  logic              w_wr_ok;
  logic              w_copy_we;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_rom_data;

  code_default_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .addr (r_cnt),
    .data (w_rom_data)
  );

  // Write acceptance: only when serving, no reload pending, CPU halted and
  // the target lies above the protected BIOS region. Reload wins over a write.
  always_comb begin
    w_ready    = (r_state == ST_READY);
    w_wr_ok    = w_ready && !reload && wr_en && !run &&
                 ({1'b0, wr_addr} >= c_bios_lim);
    w_copy_we  = (r_state == ST_INIT) && !reload;
    w_mem_we   = w_copy_we || w_wr_ok;
    w_mem_addr = w_copy_we ? r_cnt      : wr_addr;
    w_mem_data = w_copy_we ? w_rom_data : wr_data;
  end

  // Single write port shared by the image copy and loader writes; no reset
  // term so the array maps onto RAM.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Controller FSM with registered read path, busy and write-error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b1;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_err   <= wr_en && !w_wr_ok;
      r_rd_valid <= w_ready && rd_en;
      // Read sees the array before this edge's write: old data on collision.
      if (w_ready && rd_en) begin
        r_rd_data <= r_mem[rd_addr];
      end
      case (r_state)
        ST_INIT: begin
          if (reload) begin
            r_cnt <= '0;
          end else if (r_cnt == c_last) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (reload) begin
            r_state <= ST_INIT;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign busy     = r_busy;
  assign wr_err   = r_wr_err;

endmodule : code_mem_ctrl
`default_nettype wire

// File: tb/tb_code_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_mem_ctrl
// Description : Self-checking bench for code_mem_ctrl: boot copy, directed
//               read/write vectors, reload and mid-copy reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_mem_ctrl;
  import code_mem_ctrl_pkg::*;

  typedef struct {
    logic        run;
    logic        reload;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        exp_valid;
    logic        chk_data;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        run     = 1'b0;
  logic        reload  = 1'b0;
  logic        wr_en   = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en   = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        wr_err;

  int     checks   = 0;
  int     failures = 0;
  image_t img;
  vec_t   vecs [15];

  always #5 clock = ~clock;

  code_mem_ctrl #(
    .DATA_W     (16),
    .ADDR_W     (6),
    .BIOS_WORDS (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .reload   (reload),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .wr_err   (wr_err)
  );

  function automatic vec_t mk(input logic r, input logic rl, input logic we,
                              input logic [5:0] wa, input logic [15:0] wd,
                              input logic re, input logic [5:0] ra,
                              input logic ev, input logic cd,
                              input logic [15:0] ed, input logic ee);
    vec_t v;
    v.run = r; v.reload = rl; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_en = re; v.rd_addr = ra; v.exp_valid = ev; v.chk_data = cd;
    v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    run = 1'b0; reload = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  // Counts samples with busy high, starting with the current one.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      tick();
    end
  endtask

  task automatic read_one(input string nm, input logic [5:0] a, input logic [15:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    check(nm, {rd_valid, rd_data}, {1'b1, exp});
    rd_en = 1'b0;
  endtask

  task automatic read_all(input string nm);
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      rd_en = 1'b1; rd_addr = a;
      tick();
      check(nm, {rd_valid, rd_data}, {1'b1, img[a]});
    end
    rd_en = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    img = DEFAULT_IMAGE;

    vecs[0]  = mk(0,0,1,6'd40,16'hA5A5,0,6'd0, 0,0,16'h0,     1'b0);
    vecs[1]  = mk(0,0,0,6'd0, 16'h0,   1,6'd40,1,1,16'hA5A5,  1'b0);
    vecs[2]  = mk(0,0,1,6'd5, 16'h1111,0,6'd0, 0,0,16'h0,     1'b1);
    vecs[3]  = mk(0,0,0,6'd0, 16'h0,   1,6'd5, 1,1,img[6'd5], 1'b0);
    vecs[4]  = mk(1,0,1,6'd50,16'h1234,0,6'd0, 0,0,16'h0,     1'b1);
    vecs[5]  = mk(1,0,0,6'd0, 16'h0,   1,6'd50,1,1,img[6'd50],1'b0);
    vecs[6]  = mk(0,0,1,6'd45,16'hBEEF,1,6'd45,1,1,img[6'd45],1'b0);
    vecs[7]  = mk(0,0,0,6'd0, 16'h0,   1,6'd45,1,1,16'hBEEF,  1'b0);
    vecs[8]  = mk(0,0,1,6'd31,16'h3131,0,6'd0, 0,0,16'h0,     1'b1);
    vecs[9]  = mk(0,0,1,6'd32,16'h3232,0,6'd0, 0,0,16'h0,     1'b0);
    vecs[10] = mk(0,0,0,6'd0, 16'h0,   1,6'd32,1,1,16'h3232,  1'b0);
    vecs[11] = mk(0,0,0,6'd0, 16'h0,   1,6'd31,1,1,img[6'd31],1'b0);
    vecs[12] = mk(0,0,1,6'd63,16'h6363,1,6'd63,1,1,img[6'd63],1'b0);
    vecs[13] = mk(0,0,0,6'd0, 16'h0,   0,6'd0, 0,1,img[6'd63],1'b0);
    vecs[14] = mk(0,0,0,6'd0, 16'h0,   1,6'd63,1,1,16'h6363,  1'b0);

    // Reset state, with read and write requests present.
    reset = 1'b0; rd_en = 1'b1; rd_addr = 6'd3; wr_en = 1'b1; wr_addr = 6'd40;
    wr_data = 16'hFFFF;
    repeat (3) tick();
    check("rst_busy", busy, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_err", wr_err, 0);

    // Boot copy: reads ignored, writes refused, exactly 64 busy cycles.
    reset = 1'b1;
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      tick();
      if (rd_valid !== 1'b0 || wr_err !== 1'b1) bad++;
    end
    check("boot_busy_len", n, 64);
    check("boot_ignores_req", bad, 0);
    check("boot_rd_data_hold", rd_data, 0);
    idle();
    tick();
    check("boot_wr_err_clear", wr_err, 0);
    read_all("boot_read");
    tick();
    check("rd_idle_valid", rd_valid, 0);
    check("rd_idle_hold", rd_data, img[6'd63]);

    // Directed vectors in READY.
    for (int i = 0; i < 15; i++) begin
      run = vecs[i].run; reload = vecs[i].reload; wr_en = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      tick();
      check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_err", i), wr_err, vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), busy, 0);
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
    end
    idle();
    tick();

    // Reload with a simultaneous write: write dropped, image restored.
    reload = 1'b1; wr_en = 1'b1; wr_addr = 6'd40; wr_data = 16'hDEAD;
    tick();
    idle();
    check("reload_wr_err", wr_err, 1);
    check("reload_busy", busy, 1);
    count_busy(n);
    check("reload_busy_len", n, 64);
    read_one("reload_rd40", 6'd40, img[6'd40]);
    read_one("reload_rd45", 6'd45, img[6'd45]);
    read_one("reload_rd32", 6'd32, img[6'd32]);

    // Reload during the copy restarts it from address 0.
    reload = 1'b1; tick(); reload = 1'b0;
    repeat (10) tick();
    reload = 1'b1; tick(); reload = 1'b0;
    count_busy(n);
    check("restart_busy_len", n, 64);

    // Reset at cnt = 20 after modifying address 60.
    wr_en = 1'b1; wr_addr = 6'd60; wr_data = 16'h7777;
    tick();
    wr_en = 1'b0;
    read_one("mod_rd60", 6'd60, 16'h7777);
    reload = 1'b1; tick(); reload = 1'b0;
    repeat (19) tick();
    wr_en = 1'b1;
    tick();
    check("pre_rst_wr_err", wr_err, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_wr_err", wr_err, 0);
    idle();
    repeat (2) tick();
    reset = 1'b1;
    count_busy(n);
    check("rerun_busy_len", n, 64);
    read_all("post_rst_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_code_mem_ctrl
`default_nettype wire

// File: doc/code_mem_ctrl.md
CODE_MEM_CTRL -- requirements
Module: code_mem_ctrl

Interface
REQ-001 Parameter DATA_W, 16, instruction width in bits.
REQ-002 Parameter ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter BIOS_WORDS, 32, words at addresses 0..BIOS_WORDS-1 that are write-protected; legal range 0..DEPTH.
REQ-004 clock  in  1  single clock for the block; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  1 = CPU executing; all writes are refused.
REQ-007 reload  in  1  single-cycle request to re-copy the default image into the memory.
REQ-008 wr_en  in  1  write request, one word per cycle.
REQ-009 wr_addr  in  ADDR_W  write address.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 rd_en  in  1  read request.
REQ-012 rd_addr  in  ADDR_W  read address (CPU program counter).
REQ-013 rd_data  out  DATA_W  registered read data.
REQ-014 rd_valid  out  1  rd_data holds the result of the request accepted in the previous cycle.
REQ-015 busy  out  1  default-image copy in progress.
REQ-016 wr_err  out  1  one-cycle pulse when a write request is refused.

Function
REQ-017 The FSM SHALL have exactly two states: INIT (copying) and READY.
REQ-018 In INIT, the block SHALL write DEFAULT_IMAGE[cnt] to mem[cnt] once per cycle with cnt = 0..DEPTH-1 and busy = 1.
REQ-019 The block SHALL move from INIT to READY in the cycle after cnt = DEPTH-1 is written; INIT therefore lasts exactly DEPTH cycles.
REQ-020 In READY, a reload pulse SHALL clear cnt and re-enter INIT on the next edge; a reload pulse during INIT SHALL restart the copy at cnt = 0.
REQ-021 In READY, a write SHALL be accepted only when wr_en = 1, run = 0 and wr_addr >= BIOS_WORDS; an accepted write updates mem[wr_addr] on the same edge.
REQ-022 A write request that is refused (run = 1, a protected address, or busy = 1) SHALL leave memory unchanged and pulse wr_err high for the following cycle.
REQ-023 When a write and a reload occur in the same cycle in READY, the reload SHALL take priority: the write is discarded and wr_err pulses.
REQ-024 In READY, a read request (rd_en = 1) SHALL load rd_data with mem[rd_addr] and set rd_valid = 1 on the next edge, giving a latency of 1 cycle and a throughput of 1 read per cycle.
REQ-025 A read and a write to the same address in the same cycle SHALL return the old (pre-write) data.
REQ-026 Read requests during INIT SHALL be ignored; rd_valid = 0 and rd_data holds its previous value.
REQ-027 When rd_en = 0, rd_valid SHALL be 0 on the next edge and rd_data SHALL hold its value.
REQ-028 Addresses SHALL be unsigned, and cnt SHALL not wrap during INIT.

Reset
REQ-029 While reset = 0: state = INIT, cnt = 0, rd_data = 0, rd_valid = 0, wr_err = 0, busy = 1.
REQ-030 Memory contents SHALL not be reset directly; they are rebuilt by the INIT copy that starts at the first edge after reset deasserts.
REQ-031 If reset asserts mid-copy or mid-operation, all outputs SHALL take their reset values immediately and the copy SHALL restart from address 0.

Structure
REQ-032 A shared package SHALL hold the state enum, the DATA_W and ADDR_W defaults, and the DEFAULT_IMAGE constant (the BIOS words followed by the user program image).
REQ-033 The default image SHALL live in a sub-module, code_default_rom: a combinational lookup from address to DEFAULT_IMAGE[address].
REQ-034 Storage SHALL be a single-write-port, single-read-port array with no reset term, so that it can infer RAM.

Verification
REQ-035 Release reset -> busy = 1 for exactly 64 cycles, then 0; reads of all 64 addresses return DEFAULT_IMAGE, each with rd_valid one cycle after rd_en.
REQ-036 With run = 0, write 16'hA5A5 to address 40, then read address 40 -> rd_data = 16'hA5A5; write to address 5 -> wr_err pulse and mem[5] unchanged.
REQ-037 With run = 1, write 16'h1234 to address 50 -> wr_err pulse; reading address 50 returns the default value.
REQ-038 Read and write 16'hBEEF to address 45 in the same cycle -> rd_data = old value; the following read returns 16'hBEEF.
REQ-039 After modifying address 40, pulse reload together with a write -> the write is dropped, wr_err pulses, busy = 1 for 64 cycles, and address 40 returns its default value.
REQ-040 Assert reset at cnt = 20 -> outputs take reset values immediately; after release a full 64-cycle copy runs and all words match DEFAULT_IMAGE.
